// File: rtl/ariane_pkg.sv
// Shared LSU <-> D$ request-port types plus the responder FSM state and stall-LFSR polynomial.
package ariane_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    DRESP_IDLE     = 2'd0,
    DRESP_WAIT_TAG = 2'd1,
    DRESP_MEM      = 2'd2,
    DRESP_RESP     = 2'd3
  } dresp_state_e;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] DRESP_LFSR_POLY = 16'hB400;
endpackage

// File: rtl/dcache_port_responder_lfsr.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random grant stalls.
import ariane_pkg::*;

module dcache_resp_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);
  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[14:0], ^(state_q & DRESP_LFSR_POLY)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/dcache_port_responder.sv
// Cache-side endpoint of the D$ request port, backed by a single-port 64-bit SRAM.
// Optional random grant stalls are enabled with DCACHE_RESP_STALL_EN.
import ariane_pkg::*;

module dcache_port_responder #(
  parameter int          MEM_AW     = 16,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  dcache_req_i_t     req_port_i,
  output dcache_req_o_t     req_port_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic [63:0]       mem_rdata_i
);
  localparam int AW = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH;

  dresp_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic          we_q, we_d;
  logic          stall, gnt;
  logic          unused_bits;

`ifdef DCACHE_RESP_STALL_EN
  logic [15:0] lfsr;

  dcache_resp_lfsr #(.SEED(STALL_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  assign stall       = (lfsr[1:0] == 2'b00);
  assign unused_bits = ^{req_port_i.data_size, addr_q[2:0], addr_q[AW-1:MEM_AW+3], lfsr[15:2]};
`else
  assign stall       = 1'b0;
  assign unused_bits = ^{req_port_i.data_size, addr_q[2:0], addr_q[AW-1:MEM_AW+3], STALL_SEED};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    gnt     = 1'b0;
    case (state_q)
      DRESP_IDLE: begin
        gnt = req_port_i.data_req & ~stall;
        if (gnt) begin
          we_d = req_port_i.data_we;
          be_d = req_port_i.data_be;
          if (req_port_i.data_we) begin
            addr_d  = {req_port_i.address_tag, req_port_i.address_index};
            wdata_d = req_port_i.data_wdata;
            state_d = DRESP_MEM;
          end else begin
            addr_d[DCACHE_INDEX_WIDTH-1:0] = req_port_i.address_index;
            state_d = DRESP_WAIT_TAG;
          end
        end
      end
      // kill wins over a tag arriving in the same cycle
      DRESP_WAIT_TAG: begin
        if (req_port_i.kill_req) begin
          state_d = DRESP_IDLE;
        end else if (req_port_i.tag_valid) begin
          addr_d[AW-1:DCACHE_INDEX_WIDTH] = req_port_i.address_tag;
          state_d = DRESP_MEM;
        end
      end
      DRESP_MEM:  if (mem_gnt_i) state_d = DRESP_RESP;
      DRESP_RESP: state_d = DRESP_IDLE;
      default:    state_d = DRESP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DRESP_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  assign req_port_o.data_gnt    = gnt;
  assign req_port_o.data_rvalid = (state_q == DRESP_RESP);
  assign req_port_o.data_rdata  = ((state_q == DRESP_RESP) && !we_q) ? mem_rdata_i : 64'd0;

  assign mem_req_o   = (state_q == DRESP_MEM);
  assign mem_we_o    = (state_q == DRESP_MEM) & we_q;
  assign mem_addr_o  = addr_q[MEM_AW+2:3];
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
endmodule

// File: tb/tb_dcache_port_responder.sv
// Directed bench for dcache_port_responder with a behavioural zero/n-wait SRAM.
module tb_dcache_port_responder;
  import ariane_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  dcache_req_i_t req;
  dcache_req_o_t resp;
  logic          mem_req, mem_we, mem_gnt;
  logic [15:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_be;
  logic [63:0]   mem [0:65535];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  dcache_port_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_port_i  (req),
    .req_port_o  (resp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_gnt_i   (mem_gnt),
    .mem_rdata_i (mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

`ifdef DCACHE_RESP_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
  always @(negedge clk)
    if (rst_n && resp.data_gnt) chk("gnt_while_stalled", lfsr_m[1:0] != 2'b00, 1'b1);
`endif

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [43:0] t, input logic [11:0] ix, input logic [63:0] wd,
                          input logic [7:0] be, input logic [15:0] exp_addr);
    req.data_req = 1'b1; req.data_we = 1'b1; req.address_tag = t; req.address_index = ix;
    req.data_wdata = wd; req.data_be = be;
    @(negedge clk);
    chk("st_gnt", resp.data_gnt, 1'b1);
    chk("st_rvalid0", resp.data_rvalid, 1'b0);
    tick();
    req.data_req = 1'b0; req.data_we = 1'b0;
    @(negedge clk);
    chk("st_mem_req", mem_req, 1'b1);
    chk("st_mem_we", mem_we, 1'b1);
    chk("st_mem_addr", mem_addr, exp_addr);
    chk("st_mem_wdata", mem_wdata, wd);
    chk("st_mem_be", mem_be, be);
    chk("st_no_gnt", resp.data_gnt, 1'b0);
    tick();
    @(negedge clk);
    chk("st_rvalid", resp.data_rvalid, 1'b1);
    chk("st_rdata", resp.data_rdata, 64'd0);
    tick();
  endtask

  task automatic do_load(input logic [43:0] t, input logic [11:0] ix,
                         input logic [15:0] exp_addr, input logic [63:0] exp_data);
    req.data_req = 1'b1; req.data_we = 1'b0; req.address_index = ix; req.data_be = 8'hFF;
    req.address_tag = '0;
    @(negedge clk);
    chk("ld_gnt", resp.data_gnt, 1'b1);
    tick();
    req.data_req = 1'b0; req.tag_valid = 1'b1; req.address_tag = t;
    @(negedge clk);
    chk("ld_waittag_no_mem", mem_req, 1'b0);
    tick();
    req.tag_valid = 1'b0;
    @(negedge clk);
    chk("ld_mem_req", mem_req, 1'b1);
    chk("ld_mem_we", mem_we, 1'b0);
    chk("ld_mem_addr", mem_addr, exp_addr);
    tick();
    @(negedge clk);
    chk("ld_rvalid", resp.data_rvalid, 1'b1);
    chk("ld_rdata", resp.data_rdata, exp_data);
    tick();
    @(negedge clk);
    chk("ld_rvalid_1cyc", resp.data_rvalid, 1'b0);
    tick();
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 64'd0;
    mem_rdata = 64'd0;
    req = '0;
    mem_gnt = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", resp.data_gnt, 1'b0);
    chk("rst_rvalid", resp.data_rvalid, 1'b0);
    chk("rst_rdata", resp.data_rdata, 64'd0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, 90'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifndef DCACHE_RESP_STALL_EN
    do_store(44'h0, 12'h010, 64'h1122334455667788, 8'hFF, 16'h0002);
    do_load(44'h0, 12'h010, 16'h0002, 64'h1122334455667788);
    do_store(44'h0, 12'h010, 64'hFFFFFFFF_DEADBEEF, 8'h0F, 16'h0002);
    do_load(44'h0, 12'h010, 16'h0002, 64'h11223344DEADBEEF);
    do_store(44'h0, 12'h010, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 16'h0002);
    do_load(44'h0, 12'h010, 16'h0002, 64'h11223344DEADBEEF);
    do_store(44'h80, 12'h008, 64'hCAFEF00D_0BADC0DE, 8'hFF, 16'h0001);
    do_load(44'h0, 12'h008, 16'h0001, 64'hCAFEF00D_0BADC0DE);

    req.data_req = 1'b1; req.data_we = 1'b0; req.address_index = 12'h010; req.data_be = 8'hFF;
    @(negedge clk);
    chk("kill_ld_gnt", resp.data_gnt, 1'b1);
    tick();
    req.data_req = 1'b0; req.kill_req = 1'b1; req.tag_valid = 1'b1;
    @(negedge clk);
    chk("kill_no_mem", mem_req, 1'b0);
    chk("kill_no_rvalid", resp.data_rvalid, 1'b0);
    tick();
    req.kill_req = 1'b0; req.tag_valid = 1'b0;
    do_store(44'h0, 12'h020, 64'h0123456789ABCDEF, 8'hFF, 16'h0004);

    req.data_req = 1'b1; req.data_we = 1'b1; req.address_tag = '0; req.address_index = 12'h018;
    req.data_wdata = 64'hA5A5A5A5_5A5A5A5A; req.data_be = 8'hF0;
    @(negedge clk);
    chk("bp_gnt", resp.data_gnt, 1'b1);
    tick();
    mem_gnt = 1'b0;
    req.data_we = 1'b0; req.address_index = 12'h010; req.data_be = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_mem_req", mem_req, 1'b1);
      chk("bp_mem_we", mem_we, 1'b1);
      chk("bp_mem_addr", mem_addr, 16'h0003);
      chk("bp_mem_wdata", mem_wdata, 64'hA5A5A5A5_5A5A5A5A);
      chk("bp_mem_be", mem_be, 8'hF0);
      chk("bp_no_gnt", resp.data_gnt, 1'b0);
      tick();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("bp_mem_req_gnt", mem_req, 1'b1);
    chk("bp_rvalid_early", resp.data_rvalid, 1'b0);
    tick();
    @(negedge clk);
    chk("bp_rvalid", resp.data_rvalid, 1'b1);
    chk("bp_resp_no_gnt", resp.data_gnt, 1'b0);
    tick();
    @(negedge clk);
    chk("bp_idle_gnt", resp.data_gnt, 1'b1);
    tick();
    req.data_req = 1'b0; req.kill_req = 1'b1;
    tick();
    req.kill_req = 1'b0;
    chk("bp_mem_word", mem[3], 64'hA5A5A5A5_00000000);

    mem_gnt = 1'b0;
    req.data_req = 1'b1; req.data_we = 1'b1; req.address_index = 12'h028;
    req.data_wdata = 64'hFFFF; req.data_be = 8'hFF;
    tick();
    req.data_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_rvalid", resp.data_rvalid, 1'b0);
    tick();
    rst_n = 1'b1; mem_gnt = 1'b1;
    tick();
    chk("rst_mid_no_write", mem[5], 64'd0);
    do_load(44'h0, 12'h020, 16'h0004, 64'h0123456789ABCDEF);
`else
    for (int i = 0; i < 100; i++) begin
      int n;
      req.data_req = 1'b1; req.data_we = 1'b1; req.address_tag = '0;
      req.address_index = 12'(i * 8); req.data_wdata = {32'(i), 32'h5EED0000};
      req.data_be = 8'hFF;
      n = 0;
      @(negedge clk);
      while (!resp.data_gnt && n < 50) begin @(negedge clk); n++; end
      chk("stall_gnt_seen", resp.data_gnt, 1'b1);
      tick();
      req.data_req = 1'b0;
      n = 0;
      @(negedge clk);
      while (!resp.data_rvalid && n < 10) begin @(negedge clk); n++; end
      chk("stall_rvalid_seen", resp.data_rvalid, 1'b1);
      tick();
    end
    for (int i = 0; i < 100; i += 11)
      chk("stall_mem_word", mem[i], {32'(i), 32'h5EED0000});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_port_responder.md
Name: dcache_port_responder

Overview:
- Responder for the D$ request-port protocol (dcache_req_i_t in, dcache_req_o_t out), as seen from the cache side.
- Accepts store and load requests from a store/load unit and grants them.
- Handles the two-phase load address (index first, tag later), honours kill_req, and performs the access on a simple single-port 64-bit SRAM.
- Returns data_rvalid/data_rdata.
- Used as the cache-side endpoint in unit-level LSU benches and as a minimal uncached scratchpad port.

Parameters:
- MEM_AW, 16, SRAM word-address width (64-bit words); the physical address is truncated to bits [MEM_AW+2:3].
- STALL_SEED, 16'hACE1, LFSR seed; used only when DCACHE_RESP_STALL_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_port_i  in  dcache_req_i_t  request from LSU: address_index, address_tag, data_wdata, data_req, data_we, data_be, data_size, kill_req, tag_valid
- req_port_o  out  dcache_req_o_t  response: data_gnt, data_rvalid, data_rdata
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_wdata_o  out  64  SRAM write data
- mem_be_o  out  8  SRAM byte enables
- mem_gnt_i  in  1  SRAM accepts the request this cycle
- mem_rdata_i  in  64  SRAM read data, valid the cycle after the mem_gnt_i of a read

Behaviour:
- Reset values: data_gnt=0, data_rvalid=0, data_rdata=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0. FSM state is IDLE.
- Only one request is outstanding at a time. data_gnt is asserted only in IDLE.
- IDLE:
  - data_gnt = data_req (combinational, same cycle) unless stalled (see Optional Feature).
  - On a granted store (data_we=1): capture {address_tag, address_index}, wdata and be; go to MEM.
  - On a granted load: capture address_index and be; go to WAIT_TAG.
- WAIT_TAG:
  - kill_req=1 → go to IDLE, no rvalid, no SRAM access. kill_req wins over a simultaneous tag_valid.
  - tag_valid=1 → capture address_tag; go to MEM.
  - Stay otherwise; there is no timeout.
- MEM:
  - mem_req_o=1, mem_we_o=captured data_we, plus address, data and be from the captured registers.
  - Outputs are held stable until mem_gnt_i; then go to RESP.
  - kill_req is ignored from MEM onward.
- RESP:
  - data_rvalid=1 for exactly one cycle; then go to IDLE.
  - data_rdata = mem_rdata_i for loads, 0 for stores.
  - A new data_req in RESP is not granted; it waits for IDLE.
- Minimum latencies with a zero-wait SRAM:
  - store: gnt in cycle 0, rvalid in cycle 2;
  - load with tag in cycle 1: rvalid in cycle 3.
- Addressing:
  - full address = {address_tag, address_index}.
  - mem_addr_o = full address [MEM_AW+2:3]; higher bits are ignored and wrap around the SRAM.
  - data_size is not used; be is authoritative.
- A store with be=0 still performs the SRAM cycle (no bytes written) and returns rvalid.
- Reset mid-operation returns to IDLE immediately and drops any pending rvalid.

Optional Feature:
- Macro: DCACHE_RESP_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded with STALL_SEED on reset) advances every cycle.
  - In IDLE, data_gnt is suppressed when lfsr[1:0]==2'b00.
  - data_req must be held; the captured request is the one present in the granting cycle.
- Undefined: no LFSR; data_gnt is granted every IDLE cycle data_req is high.

Decomposition:
- Package: the state enum type and the 16-bit LFSR polynomial constant go in ariane_pkg. dcache_req_i_t and dcache_req_o_t are already there.
- Sub-module: dcache_resp_lfsr (seed parameter, enable, 16-bit state output), instantiated only under the macro.

Test Plan:
- Store:
  - Stimulus: data_req=1, data_we=1, tag=0, index=12'h010, wdata=64'h1122334455667788, be=8'hFF, zero-wait SRAM.
  - Response: gnt in cycle 0; mem_addr_o=0x002 with we=1 in cycle 1; rvalid in cycle 2 with rdata=0.
- Load after store:
  - Stimulus: store as above, then load index=12'h010 with tag_valid the next cycle.
  - Response: rvalid 2 cycles after the tag with rdata=64'h1122334455667788.
- Partial store:
  - Stimulus: be=8'h0F, wdata=64'hFFFFFFFF_DEADBEEF to the same word, then a load.
  - Response: rdata=64'h11223344DEADBEEF.
- Kill:
  - Stimulus: load granted, then kill_req=1 and tag_valid=1 in the same cycle.
  - Response: no mem_req_o, no rvalid; FSM back in IDLE and the next request is granted.
- SRAM backpressure:
  - Stimulus: mem_gnt_i held low for 3 cycles.
  - Response: mem_* outputs stable for all 3 cycles; rvalid 1 cycle after gnt; data_req in the meantime is not granted.
- Stall feature (macro defined, STALL_SEED default):
  - Stimulus: 100 back-to-back stores.
  - Response: all complete in order; gnt is never high while lfsr[1:0]==0.
